// File: rtl/esm_dispatch_unit.sv
// ---------------------------------------------------------------------------
// esm_dispatch_unit
//
// Purpose:
//   Consumer side of the ESM dependency analysis. It holds one dependency
//   row per instruction buffer slot. Bit j of row i means "slot i waits on
//   producer slot j". The unit tracks valid/issued state per slot and offers
//   at most one ready entry per cycle to execution over a valid/ready
//   handshake. When a slot completes, its column is cleared in every row and
//   the slot is freed.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   alloc_valid   write alloc_deps into slot alloc_index this cycle
//   alloc_index   slot being allocated
//   alloc_deps    dependency row (bit j = waits on slot j)
//   alloc_err     registered 1-cycle pulse: allocation hit a still-valid slot
//   iss_valid     registered: iss_index holds a ready entry
//   iss_ready     execution accepts the offered entry
//   iss_index     slot being offered
//   cmpl_valid    completion strobe
//   cmpl_index    slot that completed
//   occupancy     number of valid slots (0..BS)
//   full, empty   occupancy == BS / occupancy == 0
//   stat_issued   (ESM_DISPATCH_STATS_EN only) saturating issue handshake count
//   stat_stall    (ESM_DISPATCH_STATS_EN only) saturating count of cycles with
//                 valid entries, nothing ready and no offer pending
//
// Configuration macro: ESM_DISPATCH_STATS_EN
// ---------------------------------------------------------------------------
module esm_dispatch_unit #(
  parameter int BS = 16,
  localparam int IW = $clog2(BS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_valid,
  input  logic [IW-1:0] alloc_index,
  input  logic [BS-1:0] alloc_deps,
  output logic          alloc_err,
  output logic          iss_valid,
  input  logic          iss_ready,
  output logic [IW-1:0] iss_index,
  input  logic          cmpl_valid,
  input  logic [IW-1:0] cmpl_index,
  output logic [IW:0]   occupancy,
  output logic          full,
  output logic          empty
`ifdef ESM_DISPATCH_STATS_EN
  ,
  output logic [31:0]   stat_issued,
  output logic [31:0]   stat_stall
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [BS-1:0] valid_q, valid_d;
  logic [BS-1:0] issued_q, issued_d;
  logic [BS-1:0] row_q [BS];
  logic [BS-1:0] row_d [BS];
  logic [IW-1:0] iss_index_q, iss_index_d;
  logic          alloc_err_q, alloc_err_d;
  logic [IW:0]   occ_q, occ_d;

  logic [BS-1:0] ready;
  logic [BS-1:0] cmpl_col;
  logic [BS-1:0] self_bit;
  logic [IW-1:0] first_ready;
  logic          any_ready;
  logic          cmpl_acc;
  logic          alloc_acc;
  logic          handshake;

  // An entry is ready once it is valid, not yet issued and waits on nobody.
  always_comb begin
    ready = '0;
    for (int i = 0; i < BS; i++) begin
      ready[i] = valid_q[i] & ~issued_q[i] & (row_q[i] == '0);
    end
  end

  // Lowest-index ready entry; scanning downward lets the lowest index win.
  always_comb begin
    first_ready = '0;
    for (int i = BS - 1; i >= 0; i--) begin
      if (ready[i]) begin
        first_ready = IW'(i);
      end
    end
  end

  assign any_ready = |ready;
  assign handshake = (state_q == OFFER) & iss_ready;

  // Only an issued entry can complete; anything else is dropped silently.
  // Completion is resolved first so the same slot may be reallocated in the
  // same cycle.
  assign cmpl_acc  = cmpl_valid & valid_q[cmpl_index] & issued_q[cmpl_index];
  assign cmpl_col  = cmpl_acc ? ({{(BS-1){1'b0}}, 1'b1} << cmpl_index) : '0;
  assign self_bit  = {{(BS-1){1'b0}}, 1'b1} << alloc_index;
  assign alloc_acc = alloc_valid & ~(valid_q[alloc_index] & ~cmpl_col[alloc_index]);

  // Slot table update: completion clears the column, then allocation writes
  // the new row. The row keeps only dependences on slots that remain live.
  always_comb begin
    valid_d  = valid_q & ~cmpl_col;
    issued_d = issued_q & ~cmpl_col;
    for (int i = 0; i < BS; i++) begin
      row_d[i] = row_q[i] & ~cmpl_col;
    end
    if (handshake) begin
      issued_d[iss_index_q] = 1'b1;
    end
    if (alloc_acc) begin
      valid_d[alloc_index]  = 1'b1;
      issued_d[alloc_index] = 1'b0;
      row_d[alloc_index]    = alloc_deps & valid_q & ~cmpl_col & ~self_bit;
    end
    alloc_err_d = alloc_valid & ~alloc_acc;
    occ_d       = occ_q + (IW+1)'(alloc_acc) - (IW+1)'(cmpl_acc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      issued_q    <= '0;
      alloc_err_q <= 1'b0;
      occ_q       <= '0;
      for (int i = 0; i < BS; i++) begin
        row_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      issued_q    <= issued_d;
      alloc_err_q <= alloc_err_d;
      occ_q       <= occ_d;
      for (int i = 0; i < BS; i++) begin
        row_q[i] <= row_d[i];
      end
    end
  end

  // Issue FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      iss_index_q <= '0;
    end else begin
      state_q     <= state_d;
      iss_index_q <= iss_index_d;
    end
  end

  // Issue FSM: next state. The offered index is latched on entry to OFFER and
  // held until accepted. Its row cannot become nonzero while it is offered,
  // so the offer is never withdrawn.
  always_comb begin
    state_d     = state_q;
    iss_index_d = iss_index_q;
    case (state_q)
      IDLE: begin
        if (any_ready) begin
          state_d     = OFFER;
          iss_index_d = first_ready;
        end
      end
      OFFER: begin
        if (iss_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue FSM: outputs.
  always_comb begin
    iss_valid = (state_q == OFFER);
    iss_index = iss_index_q;
  end

  assign alloc_err = alloc_err_q;
  assign occupancy = occ_q;
  assign full      = (occ_q == (IW+1)'(BS));
  assign empty     = (occ_q == '0);

`ifdef ESM_DISPATCH_STATS_EN
  logic [31:0] stat_issued_q;
  logic [31:0] stat_stall_q;
  logic        stall_now;

  // A stall cycle has live entries but nothing offered and nothing offerable.
  assign stall_now = (occ_q != '0) & ~any_ready & (state_q == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (handshake && (stat_issued_q != 32'hFFFF_FFFF)) begin
        stat_issued_q <= stat_issued_q + 32'd1;
      end
      if (stall_now && (stat_stall_q != 32'hFFFF_FFFF)) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_esm_dispatch_unit.sv
// ---------------------------------------------------------------------------
// tb_esm_dispatch_unit
//
// Self-checking bench for esm_dispatch_unit (BS = 16). Directed scenarios
// check the documented timing with constant expectations. A randomized run
// compares every output each cycle against a slot-level reference model:
// sets of live, issued and pending producers per slot, plus one pending offer.
// Stats checks are compiled only with ESM_DISPATCH_STATS_EN.
// ---------------------------------------------------------------------------
module tb_esm_dispatch_unit;

  localparam int BS = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid;
  logic [IW-1:0] alloc_index;
  logic [BS-1:0] alloc_deps;
  logic          alloc_err;
  logic          iss_valid;
  logic          iss_ready;
  logic [IW-1:0] iss_index;
  logic          cmpl_valid;
  logic [IW-1:0] cmpl_index;
  logic [IW:0]   occupancy;
  logic          full;
  logic          empty;
`ifdef ESM_DISPATCH_STATS_EN
  logic [31:0]   stat_issued;
  logic [31:0]   stat_stall;
`endif

  int checks;
  int errors;

  esm_dispatch_unit #(.BS(BS)) dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_index (alloc_index),
    .alloc_deps  (alloc_deps),
    .alloc_err   (alloc_err),
    .iss_valid   (iss_valid),
    .iss_ready   (iss_ready),
    .iss_index   (iss_index),
    .cmpl_valid  (cmpl_valid),
    .cmpl_index  (cmpl_index),
    .occupancy   (occupancy),
    .full        (full),
    .empty       (empty)
`ifdef ESM_DISPATCH_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: per-slot live/issued flags and the set of producers
  // each slot still waits on; one pending offer with its slot number.
  bit [BS-1:0] m_live;
  bit [BS-1:0] m_done_issue;
  bit [BS-1:0] m_waits [BS];
  bit          m_offer;
  int          m_slot;
  bit          m_err;
  longint      m_n_issued;
  longint      m_n_stall;

  // Clears the reference model to its post-reset state.
  task automatic model_reset();
    m_live = '0;
    m_done_issue = '0;
    for (int i = 0; i < BS; i++) m_waits[i] = '0;
    m_offer = 1'b0;
    m_slot = 0;
    m_err = 1'b0;
    m_n_issued = 0;
    m_n_stall = 0;
  endtask

  // Advances the reference model by one clock edge, using the inputs the DUT sees.
  task automatic model_step();
    bit [BS-1:0] offerable;
    bit          took;
    bit          found;
    int          c;
    int          a;
    offerable = '0;
    for (int i = 0; i < BS; i++)
      offerable[i] = m_live[i] && !m_done_issue[i] && (m_waits[i] == '0);
    took = m_offer && iss_ready;
    if (took) m_n_issued++;
    if (($countones(m_live) != 0) && (offerable == '0) && !m_offer) m_n_stall++;
    c = int'(cmpl_index);
    if (cmpl_valid && m_live[c] && m_done_issue[c]) begin
      m_live[c] = 1'b0;
      m_done_issue[c] = 1'b0;
      for (int j = 0; j < BS; j++) m_waits[j][c] = 1'b0;
    end
    m_err = 1'b0;
    a = int'(alloc_index);
    if (alloc_valid) begin
      if (m_live[a]) begin
        m_err = 1'b1;
      end else begin
        m_waits[a] = alloc_deps & m_live;
        m_waits[a][a] = 1'b0;
        m_live[a] = 1'b1;
        m_done_issue[a] = 1'b0;
      end
    end
    if (m_offer) begin
      if (took) begin
        m_done_issue[m_slot] = 1'b1;
        m_offer = 1'b0;
      end
    end else begin
      found = 1'b0;
      for (int i = 0; i < BS; i++) begin
        if (!found && offerable[i]) begin
          found = 1'b1;
          m_offer = 1'b1;
          m_slot = i;
        end
      end
    end
  endtask

  // One clock edge: update the model at the edge, then settle for sampling.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Applies reset between edges and clears all stimulus.
  task automatic do_reset();
    rst = 1'b1;
    alloc_valid = 1'b0;
    alloc_index = '0;
    alloc_deps = '0;
    iss_ready = 1'b0;
    cmpl_valid = 1'b0;
    cmpl_index = '0;
    model_reset();
    #3;
    rst = 1'b0;
  endtask

  // Holds reset and checks every output's reset value.
  task automatic test_reset();
    do_reset();
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_iss_valid actual=%0b expected=0", iss_valid); end
    checks++; if (iss_index !== 4'd0) begin errors++; $display("[TB] FAIL reset_iss_index actual=%0d expected=0", iss_index); end
    checks++; if (alloc_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_alloc_err actual=%0b expected=0", alloc_err); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("[TB] FAIL reset_occupancy actual=%0d expected=0", occupancy); end
    checks++; if ({full, empty} !== 2'b01) begin errors++; $display("[TB] FAIL reset_full_empty actual=%b expected=01", {full, empty}); end
`ifdef ESM_DISPATCH_STATS_EN
    checks++; if ({stat_issued, stat_stall} !== 64'd0) begin errors++; $display("[TB] FAIL reset_stats actual=%0d/%0d expected=0/0", stat_issued, stat_stall); end
`endif
  endtask

  // Allocates zero-dependency slot 3 and checks the offer timing.
  task automatic test_basic_issue();
    do_reset();
    iss_ready = 1'b1;
    alloc_valid = 1'b1; alloc_index = 4'd3; alloc_deps = '0;
    tick();
    alloc_valid = 1'b0;
    checks++; if ({iss_valid, occupancy} !== {1'b0, 5'd1}) begin errors++; $display("[TB] FAIL basic_after_E actual=%0b/%0d expected=0/1", iss_valid, occupancy); end
    tick();
    checks++; if ({iss_valid, iss_index} !== {1'b1, 4'd3}) begin errors++; $display("[TB] FAIL basic_offer actual=%0b/%0d expected=1/3", iss_valid, iss_index); end
    checks++; if ({occupancy, empty} !== {5'd1, 1'b0}) begin errors++; $display("[TB] FAIL basic_occ actual=%0d/%0b expected=1/0", occupancy, empty); end
  endtask

  // Slot 5 waits on slot 2 and may only issue after slot 2 completes.
  task automatic test_dependency();
    do_reset();
    alloc_valid = 1'b1; alloc_index = 4'd2; alloc_deps = '0;
    tick();
    alloc_index = 4'd5; alloc_deps = 16'h0004;
    tick();
    alloc_valid = 1'b0;
    checks++; if ({iss_valid, iss_index} !== {1'b1, 4'd2}) begin errors++; $display("[TB] FAIL dep_offer2 actual=%0b/%0d expected=1/2", iss_valid, iss_index); end
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    tick();
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("[TB] FAIL dep_blocked actual=%0b expected=0", iss_valid); end
    cmpl_valid = 1'b1; cmpl_index = 4'd2;
    tick();
    cmpl_valid = 1'b0;
    checks++; if ({iss_valid, occupancy} !== {1'b0, 5'd1}) begin errors++; $display("[TB] FAIL dep_after_cmpl actual=%0b/%0d expected=0/1", iss_valid, occupancy); end
    tick();
    checks++; if ({iss_valid, iss_index} !== {1'b1, 4'd5}) begin errors++; $display("[TB] FAIL dep_offer5 actual=%0b/%0d expected=1/5", iss_valid, iss_index); end
  endtask

  // Three independent slots issue lowest-first; a held offer stays stable.
  task automatic test_in_order_hold();
    logic [IW-1:0] order [3];
    order[0] = 4'd1; order[1] = 4'd4; order[2] = 4'd7;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      alloc_valid = 1'b1; alloc_index = order[k]; alloc_deps = '0;
      tick();
    end
    alloc_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++; if ({iss_valid, iss_index} !== {1'b1, 4'd1}) begin errors++; $display("[TB] FAIL hold_cycle%0d actual=%0b/%0d expected=1/1", c, iss_valid, iss_index); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if ({iss_valid, iss_index} !== {1'b1, order[k]}) begin errors++; $display("[TB] FAIL order%0d actual=%0b/%0d expected=1/%0d", k, iss_valid, iss_index, order[k]); end
      iss_ready = 1'b1;
      tick();
      iss_ready = 1'b0;
      tick();
    end
  endtask

  // A rejected allocation leaves the row intact; completion frees a slot for same-cycle reuse.
  task automatic test_alloc_reject();
    do_reset();
    alloc_valid = 1'b1; alloc_index = 4'd6; alloc_deps = '0;
    tick();
    alloc_index = 4'd9;
    tick();
    alloc_index = 4'd9; alloc_deps = 16'h0040;
    tick();
    alloc_valid = 1'b0;
    checks++; if ({alloc_err, occupancy} !== {1'b1, 5'd2}) begin errors++; $display("[TB] FAIL reject_err actual=%0b/%0d expected=1/2", alloc_err, occupancy); end
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    checks++; if (alloc_err !== 1'b0) begin errors++; $display("[TB] FAIL reject_pulse actual=%0b expected=0", alloc_err); end
    tick();
    checks++; if ({iss_valid, iss_index} !== {1'b1, 4'd9}) begin errors++; $display("[TB] FAIL reject_row_kept actual=%0b/%0d expected=1/9", iss_valid, iss_index); end
    cmpl_valid = 1'b1; cmpl_index = 4'd6;
    alloc_valid = 1'b1; alloc_index = 4'd6; alloc_deps = '0;
    tick();
    cmpl_valid = 1'b0; alloc_valid = 1'b0;
    checks++; if ({alloc_err, occupancy} !== {1'b0, 5'd2}) begin errors++; $display("[TB] FAIL reuse_accept actual=%0b/%0d expected=0/2", alloc_err, occupancy); end
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    tick();
    checks++; if ({iss_valid, iss_index} !== {1'b1, 4'd6}) begin errors++; $display("[TB] FAIL reuse_offer actual=%0b/%0d expected=1/6", iss_valid, iss_index); end
  endtask

  // Fills every slot, probes rejected alloc/completion, then resets mid-offer.
  task automatic test_full_and_reset();
    do_reset();
    for (int i = 0; i < BS; i++) begin
      alloc_valid = 1'b1; alloc_index = IW'(i); alloc_deps = '0;
      tick();
    end
    alloc_valid = 1'b0;
    checks++; if ({full, empty, occupancy} !== {1'b1, 1'b0, 5'd16}) begin errors++; $display("[TB] FAIL full_set actual=%b/%b/%0d expected=1/0/16", full, empty, occupancy); end
    checks++; if ({iss_valid, iss_index} !== {1'b1, 4'd0}) begin errors++; $display("[TB] FAIL full_offer actual=%0b/%0d expected=1/0", iss_valid, iss_index); end
    alloc_valid = 1'b1; alloc_index = 4'd3;
    cmpl_valid = 1'b1; cmpl_index = 4'd5;
    tick();
    alloc_valid = 1'b0; cmpl_valid = 1'b0;
    checks++; if ({alloc_err, full, occupancy} !== {1'b1, 1'b1, 5'd16}) begin errors++; $display("[TB] FAIL full_ignore actual=%b/%b/%0d expected=1/1/16", alloc_err, full, occupancy); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({iss_valid, occupancy, empty, full} !== {1'b1 ^ 1'b1, 5'd0, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL midreset actual=%b/%0d/%b/%b expected=0/0/1/0", iss_valid, occupancy, empty, full); end
    model_reset();
    #1;
    rst = 1'b0;
  endtask

`ifdef ESM_DISPATCH_STATS_EN
  // Three issues interleaved with exactly four blocked cycles.
  task automatic test_stats();
    do_reset();
    alloc_valid = 1'b1; alloc_index = 4'd0; alloc_deps = '0;
    tick();
    alloc_valid = 1'b0;
    tick();
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    tick(); tick(); tick();
    cmpl_valid = 1'b1; cmpl_index = 4'd0;
    tick();
    cmpl_valid = 1'b0;
    alloc_valid = 1'b1; alloc_index = 4'd1;
    tick();
    alloc_valid = 1'b0;
    tick();
    iss_ready = 1'b1; alloc_valid = 1'b1; alloc_index = 4'd2;
    tick();
    iss_ready = 1'b0; alloc_valid = 1'b0;
    tick();
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    checks++; if (stat_issued !== 32'd3) begin errors++; $display("[TB] FAIL stat_issued actual=%0d expected=3", stat_issued); end
    checks++; if (stat_stall !== 32'd4) begin errors++; $display("[TB] FAIL stat_stall actual=%0d expected=4", stat_stall); end
  endtask
`endif

  // Random traffic compared every cycle against the reference model.
  task automatic test_random();
    int issued_slots [$];
    int pick;
    int bad;
    do_reset();
    bad = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      issued_slots.delete();
      for (int i = 0; i < BS; i++) if (m_live[i] && m_done_issue[i]) issued_slots.push_back(i);
      alloc_valid = ($urandom_range(0, 99) < 45);
      alloc_index = IW'($urandom_range(0, BS - 1));
      alloc_deps = BS'($urandom() & $urandom());
      iss_ready = ($urandom_range(0, 2) != 0);
      cmpl_valid = 1'b0;
      if ((issued_slots.size() > 0) && ($urandom_range(0, 99) < 45)) begin
        pick = issued_slots[$urandom_range(0, issued_slots.size() - 1)];
        cmpl_valid = 1'b1; cmpl_index = IW'(pick);
        if ($urandom_range(0, 3) == 0) alloc_index = IW'(pick);
      end else if ($urandom_range(0, 9) == 0) begin
        cmpl_valid = 1'b1; cmpl_index = IW'($urandom_range(0, BS - 1));
      end
      tick();
      checks++;
      if ({iss_valid, alloc_err} !== {m_offer, m_err} || (m_offer && (iss_index !== IW'(m_slot)))) begin
        errors++;
        if (bad++ < 10) $display("[TB] FAIL rand_issue cyc=%0d actual v=%0b idx=%0d err=%0b expected v=%0b idx=%0d err=%0b", cyc, iss_valid, iss_index, alloc_err, m_offer, m_slot, m_err);
      end
      checks++;
      if ({occupancy, full, empty} !== {5'($countones(m_live)), ($countones(m_live) == BS), ($countones(m_live) == 0)}) begin
        errors++;
        if (bad++ < 10) $display("[TB] FAIL rand_occ cyc=%0d actual=%0d/%b/%b expected=%0d", cyc, occupancy, full, empty, $countones(m_live));
      end
`ifdef ESM_DISPATCH_STATS_EN
      checks++;
      if ({stat_issued, stat_stall} !== {32'(m_n_issued), 32'(m_n_stall)}) begin
        errors++;
        if (bad++ < 10) $display("[TB] FAIL rand_stats cyc=%0d actual=%0d/%0d expected=%0d/%0d", cyc, stat_issued, stat_stall, m_n_issued, m_n_stall);
      end
`endif
    end
    alloc_valid = 1'b0; cmpl_valid = 1'b0; iss_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_issue();
    test_dependency();
    test_in_order_hold();
    test_alloc_reject();
    test_full_and_reset();
`ifdef ESM_DISPATCH_STATS_EN
    test_stats();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
